// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences CPU and AXI Lite host accesses onto shared memory port 2
module mem_port_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              mips_cpu_clk,
    input  logic              mips_cpu_resetn,
    input  logic              mips_rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic              host_req_we,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [DATA_W-1:0] host_req_wdata,
    output logic              host_resp_valid,
    output logic [DATA_W-1:0] host_resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    state_t            state, state_nxt;
    logic [7:0]        host_wait_cnt;
    logic              lat_we, lat_host;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata, rdata_q;
    logic              accept_win, host_win, cpu_win, accept;

    // arbitration: host wins under CPU reset, when alone, or once starved; ready only goes to the winner
    always_comb begin
        accept_win     = mips_cpu_resetn && (state != ACCESS);
        host_win       = accept_win && host_req_valid &&
                         (mips_rst || !cpu_req_valid || host_wait_cnt == WAIT_MAX);
        cpu_win        = accept_win && cpu_req_valid && !host_win;
        accept         = host_win || cpu_win;
        host_req_ready = host_win;
        cpu_req_ready  = cpu_win;
    end

    // state register
    always_ff @(posedge mips_cpu_clk or negedge mips_cpu_resetn) begin
        if (!mips_cpu_resetn) state <= IDLE;
        else                  state <= state_nxt;
    end

    // next state plus memory-port and response drive; everything idles at 0 outside its own state
    always_comb begin
        state_nxt       = state;
        mem_addr        = '0;
        mem_rden        = 1'b0;
        mem_wren        = 1'b0;
        mem_wdata       = '0;
        cpu_resp_valid  = 1'b0;
        cpu_resp_rdata  = '0;
        host_resp_valid = 1'b0;
        host_resp_rdata = '0;
        case (state)
            IDLE: state_nxt = accept ? ACCESS : IDLE;
            ACCESS: begin
                mem_addr  = lat_addr;
                mem_rden  = !lat_we;
                mem_wren  = lat_we;
                mem_wdata = lat_we ? lat_wdata : '0;
                state_nxt = RESP;
            end
            RESP: begin
                cpu_resp_valid  = !lat_host;
                cpu_resp_rdata  = lat_host ? '0 : rdata_q;
                host_resp_valid = lat_host;
                host_resp_rdata = lat_host ? rdata_q : '0;
                state_nxt       = accept ? ACCESS : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // latch the winning request; capture read data at the end of the access (0 for writes)
    always_ff @(posedge mips_cpu_clk or negedge mips_cpu_resetn) begin
        if (!mips_cpu_resetn) begin
            lat_we    <= 1'b0;
            lat_host  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                lat_we    <= host_win ? host_req_we    : cpu_req_we;
                lat_host  <= host_win;
                lat_addr  <= host_win ? host_req_addr  : cpu_req_addr;
                lat_wdata <= host_win ? host_req_wdata : cpu_req_wdata;
            end
            if (state == ACCESS) rdata_q <= lat_we ? '0 : mem_rdata;
        end
    end

    // host starvation counter: counts blocked host cycles, saturating, cleared on accept or idle host
    always_ff @(posedge mips_cpu_clk or negedge mips_cpu_resetn) begin
        if (!mips_cpu_resetn)                   host_wait_cnt <= '0;
        else if (!host_req_valid || host_win)   host_wait_cnt <= '0;
        else if (host_wait_cnt != WAIT_MAX)     host_wait_cnt <= host_wait_cnt + 8'd1;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a pipeline-level model
module tb_mem_port_arbiter;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          resetn, mips_rst;
    logic          cv, cr, cwe, crv, hv, hr, hwe, hrv;
    logic [AW-1:0] caddr, haddr, mem_addr;
    logic [DW-1:0] cwd, crd, hwd, hrd, mem_wdata, mem_rdata;
    logic          mem_rden, mem_wren;
    logic [112:0]  outs;

    logic [DW-1:0] tb_mem  [0:2047];
    logic [DW-1:0] ref_mem [0:2047];

    // model: transaction on the memory port this cycle, response being delivered this cycle, host wait age
    logic          m_acc_v, m_acc_host, m_acc_we, m_rsp_v, m_rsp_host;
    logic [AW-1:0] m_acc_addr;
    logic [DW-1:0] m_acc_wd, m_rsp_data;
    int            m_wait;

    logic          e_hr, e_cr, e_rden, e_wren, e_cv, e_hv;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_mwd, e_crd, e_hrd;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .mips_cpu_clk(clk), .mips_cpu_resetn(resetn), .mips_rst(mips_rst),
        .cpu_req_valid(cv), .cpu_req_ready(cr), .cpu_req_we(cwe), .cpu_req_addr(caddr),
        .cpu_req_wdata(cwd), .cpu_resp_valid(crv), .cpu_resp_rdata(crd),
        .host_req_valid(hv), .host_req_ready(hr), .host_req_we(hwe), .host_req_addr(haddr),
        .host_req_wdata(hwd), .host_resp_valid(hrv), .host_resp_rdata(hrd),
        .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = tb_mem[mem_addr];
    assign outs = {cr, hr, crv, hrv, mem_rden, mem_wren, mem_addr, mem_wdata, crd, hrd};

    always @(posedge clk) if (mem_wren) tb_mem[mem_addr] <= mem_wdata;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic void model_clear();
        m_acc_v = 1'b0;
        m_rsp_v = 1'b0;
        m_wait  = 0;
    endfunction

    function automatic void eval();
        logic win;
        win     = resetn && !m_acc_v;
        e_hr    = win && hv && (mips_rst || !cv || m_wait == MW);
        e_cr    = win && cv && !e_hr;
        e_maddr = m_acc_v ? m_acc_addr : '0;
        e_rden  = m_acc_v && !m_acc_we;
        e_wren  = m_acc_v && m_acc_we;
        e_mwd   = (m_acc_v && m_acc_we) ? m_acc_wd : '0;
        e_cv    = m_rsp_v && !m_rsp_host;
        e_hv    = m_rsp_v && m_rsp_host;
        e_crd   = e_cv ? m_rsp_data : '0;
        e_hrd   = e_hv ? m_rsp_data : '0;
    endfunction

    task automatic settle();
        #1;
        eval();
    endtask

    task automatic adv();
        eval();
        @(posedge clk);
        if (!resetn) model_clear();
        else begin
            m_rsp_v = m_acc_v;
            if (m_acc_v) begin
                m_rsp_host = m_acc_host;
                m_rsp_data = m_acc_we ? '0 : ref_mem[m_acc_addr];
                if (m_acc_we) ref_mem[m_acc_addr] = m_acc_wd;
            end
            m_acc_v = e_hr || e_cr;
            if (m_acc_v) begin
                m_acc_host = e_hr;
                m_acc_we   = e_hr ? hwe : cwe;
                m_acc_addr = e_hr ? haddr : caddr;
                m_acc_wd   = e_hr ? hwd : cwd;
            end
            m_wait = (!hv || e_hr) ? 0 : (m_wait == MW ? MW : m_wait + 1);
        end
        #1;
    endtask

    task automatic idle();
        cv = 1'b0;
        hv = 1'b0;
        repeat (3) adv();
    endtask

    task automatic test_reset();
        resetn = 1'b0; cv = 1'b1; hv = 1'b1; model_clear();
        #1;
        total++; if (outs !== '0) begin bad++; $display("FAIL reset_outs got=%h exp=0", outs); end
        repeat (2) @(posedge clk);
        #1;
        cv = 1'b0; hv = 1'b0; resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            total++; if (outs !== '0) begin bad++; $display("FAIL idle_outs cyc=%0d got=%h exp=0", i, outs); end
            adv();
        end
        cv = 1'b1; cwe = 1'b0; caddr = 11'h003;
        settle();
        total++; if (cr !== 1'b1) begin bad++; $display("FAIL pre_reset_accept got=%b exp=1", cr); end
        adv();
        cv = 1'b0;
        settle();
        total++; if (mem_rden !== 1'b1) begin bad++; $display("FAIL pre_reset_rden got=%b exp=1", mem_rden); end
        #2;
        resetn = 1'b0; model_clear();
        #1;
        total++; if ({mem_rden, mem_wren} !== 2'b00) begin bad++; $display("FAIL async_drop got=%b exp=00", {mem_rden, mem_wren}); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++; if ({crv, hrv} !== 2'b00) begin bad++; $display("FAIL dropped_resp cyc=%0d got=%b exp=00", i, {crv, hrv}); end
            adv();
        end
    endtask

    task automatic test_host_write_read();
        mips_rst = 1'b1;
        hv = 1'b1; hwe = 1'b1; haddr = 11'h005; hwd = 32'hDEADBEEF;
        settle();
        total++; if ({hr, cr} !== 2'b10) begin bad++; $display("FAIL hw_accept got=%b exp=10", {hr, cr}); end
        adv();
        hv = 1'b0;
        settle();
        total++; if ({mem_wren, mem_rden, mem_addr, mem_wdata} !== {1'b1, 1'b0, 11'h005, 32'hDEADBEEF}) begin
            bad++; $display("FAIL hw_access got=%b%b %h %h exp=10 005 deadbeef", mem_wren, mem_rden, mem_addr, mem_wdata);
        end
        adv();
        hv = 1'b1; hwe = 1'b0; hwd = '0;
        settle();
        total++; if ({hrv, hrd, hr} !== {1'b1, 32'h0, 1'b1}) begin bad++; $display("FAIL hw_resp got=%b %h %b exp=1 0 1", hrv, hrd, hr); end
        adv();
        hv = 1'b0;
        settle();
        total++; if ({mem_rden, mem_wren, mem_addr} !== {2'b10, 11'h005}) begin bad++; $display("FAIL hr_access got=%b%b %h exp=10 005", mem_rden, mem_wren, mem_addr); end
        adv();
        settle();
        total++; if ({hrv, hrd} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL hr_resp got=%b %h exp=1 deadbeef", hrv, hrd); end
        adv();
        mips_rst = 1'b0;
        idle();
    endtask

    task automatic test_starvation();
        int h_first = -1;
        int h_second = -1;
        int cpu_n = 0;
        mips_rst = 1'b0;
        hv = 1'b1; hwe = 1'b0; haddr = 11'($urandom);
        cv = 1'b1; cwe = 1'b0; caddr = 11'($urandom);
        for (int c = 0; c < 19; c++) begin
            logic took_c, took_h;
            settle();
            total++; if ({cr, hr} !== {e_cr, e_hr}) begin bad++; $display("FAIL starve_ready cyc=%0d got=%b%b exp=%b%b", c, cr, hr, e_cr, e_hr); end
            total++; if ({crv, crd, hrv, hrd} !== {e_cv, e_crd, e_hv, e_hrd}) begin
                bad++; $display("FAIL starve_resp cyc=%0d got=%b %h %b %h exp=%b %h %b %h", c, crv, crd, hrv, hrd, e_cv, e_crd, e_hv, e_hrd);
            end
            took_c = cr; took_h = hr;
            if (took_c) cpu_n++;
            if (took_h) begin if (h_first < 0) h_first = c; else h_second = c; end
            adv();
            if (took_c) caddr = 11'($urandom);
            if (took_h) haddr = 11'($urandom);
        end
        total++; if (h_first !== 8 || h_second !== 18) begin bad++; $display("FAIL starve_host_slots got=%0d,%0d exp=8,18", h_first, h_second); end
        total++; if (cpu_n !== 8) begin bad++; $display("FAIL starve_cpu_count got=%0d exp=8", cpu_n); end
        idle();
    endtask

    task automatic test_back_to_back();
        cv = 1'b1; cwe = 1'b0; caddr = 11'h1FF;
        settle();
        total++; if (cr !== 1'b1) begin bad++; $display("FAIL b2b_accept1 got=%b exp=1", cr); end
        adv();
        caddr = 11'h0AA;
        settle();
        total++; if ({mem_rden, mem_addr, cr} !== {1'b1, 11'h1FF, 1'b0}) begin bad++; $display("FAIL b2b_access1 got=%b %h %b exp=1 1ff 0", mem_rden, mem_addr, cr); end
        adv();
        settle();
        total++; if ({crv, crd, cr} !== {1'b1, ref_mem[11'h1FF], 1'b1}) begin bad++; $display("FAIL b2b_resp1 got=%b %h %b exp=1 %h 1", crv, crd, cr, ref_mem[11'h1FF]); end
        adv();
        cv = 1'b0;
        settle();
        total++; if ({mem_rden, mem_addr, crv} !== {1'b1, 11'h0AA, 1'b0}) begin bad++; $display("FAIL b2b_access2 got=%b %h %b exp=1 0aa 0", mem_rden, mem_addr, crv); end
        adv();
        settle();
        total++; if ({crv, crd} !== {1'b1, ref_mem[11'h0AA]}) begin bad++; $display("FAIL b2b_resp2 got=%b %h exp=1 %h", crv, crd, ref_mem[11'h0AA]); end
        adv();
        settle();
        total++; if ({crv, mem_rden, mem_addr} !== '0) begin bad++; $display("FAIL b2b_quiet got=%b %b %h exp=0 0 000", crv, mem_rden, mem_addr); end
        idle();
    endtask

    task automatic test_mips_rst_priority();
        mips_rst = 1'b1;
        cv = 1'b1; cwe = 1'b0; caddr = 11'h010;
        hv = 1'b1; hwe = 1'b0; haddr = 11'h020;
        settle();
        total++; if ({hr, cr} !== 2'b10) begin bad++; $display("FAIL prio_host got=%b exp=10", {hr, cr}); end
        adv();
        hv = 1'b0;
        settle();
        total++; if ({hr, cr} !== 2'b00) begin bad++; $display("FAIL prio_busy got=%b exp=00", {hr, cr}); end
        adv();
        settle();
        total++; if ({cr, hrv} !== 2'b11) begin bad++; $display("FAIL prio_cpu_next got=%b exp=11", {cr, hrv}); end
        adv();
        mips_rst = 1'b0;
        idle();
    endtask

    task automatic test_cpu_write_host_read();
        cv = 1'b1; cwe = 1'b1; caddr = 11'h00A; cwd = 32'h12345678;
        settle();
        total++; if (cr !== 1'b1) begin bad++; $display("FAIL cw_accept got=%b exp=1", cr); end
        adv();
        cv = 1'b0;
        hv = 1'b1; hwe = 1'b0; haddr = 11'h00A; hwd = '0;
        settle();
        total++; if ({mem_wren, hr} !== 2'b10) begin bad++; $display("FAIL cw_access got=%b exp=10", {mem_wren, hr}); end
        adv();
        settle();
        total++; if ({crv, crd, hr} !== {1'b1, 32'h0, 1'b1}) begin bad++; $display("FAIL cw_ack got=%b %h %b exp=1 0 1", crv, crd, hr); end
        adv();
        hv = 1'b0;
        adv();
        settle();
        total++; if ({hrv, hrd, crv} !== {1'b1, 32'h12345678, 1'b0}) begin bad++; $display("FAIL hr_after_cw got=%b %h %b exp=1 12345678 0", hrv, hrd, crv); end
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic took_c, took_h;
            if ($urandom_range(19) == 0) mips_rst = ~mips_rst;
            settle();
            total++; if ({cr, hr} !== {e_cr, e_hr}) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", c, cr, hr, e_cr, e_hr); end
            total++; if ({mem_rden, mem_wren, mem_addr, mem_wdata} !== {e_rden, e_wren, e_maddr, e_mwd}) begin
                bad++; $display("FAIL rnd_mem cyc=%0d got=%b%b %h %h exp=%b%b %h %h", c, mem_rden, mem_wren, mem_addr, mem_wdata, e_rden, e_wren, e_maddr, e_mwd);
            end
            total++; if ({crv, crd, hrv, hrd} !== {e_cv, e_crd, e_hv, e_hrd}) begin
                bad++; $display("FAIL rnd_resp cyc=%0d got=%b %h %b %h exp=%b %h %b %h", c, crv, crd, hrv, hrd, e_cv, e_crd, e_hv, e_hrd);
            end
            took_c = cr || !cv;
            took_h = hr || !hv;
            adv();
            if (took_c) begin cv = 1'($urandom); cwe = 1'($urandom); caddr = 11'($urandom); cwd = $urandom; end
            if (took_h) begin hv = 1'($urandom); hwe = 1'($urandom); haddr = 11'($urandom); hwd = $urandom; end
        end
        mips_rst = 1'b0;
        idle();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            tb_mem[i] <= v;
            ref_mem[i] = v;
        end
        resetn = 1'b0; mips_rst = 1'b0;
        cv = 1'b0; cwe = 1'b0; caddr = '0; cwd = '0;
        hv = 1'b0; hwe = 1'b0; haddr = '0; hwd = '0;
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_host_write_read();
        test_starvation();
        test_back_to_back();
        test_mips_rst_priority();
        test_cpu_write_host_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
